// File: rtl/sc_rng_pkg.sv
// Shared constants and helpers for the stochastic-computing RNG bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sc_rng_pkg;

  localparam int SC_RNG_WIDTH = 8;

  // Fibonacci tap masks; bit 7 is the x^8 term, the rest are the inner taps
  localparam logic [7:0] TAPS_A = 8'b1011_1000;  // x^8+x^6+x^5+x^4+1
  localparam logic [7:0] TAPS_B = 8'b1011_0100;  // x^8+x^6+x^5+x^3+1

  // An all-zero seed would lock the LFSR, so it is replaced by this value
  localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

  // Last step-counter value before it wraps; 255 steps equal one full period
  localparam logic [7:0] PERIOD_LAST = 8'd254;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q, input logic [7:0] taps);
    return {q[6:0], ^(q & taps)};
  endfunction

  function automatic logic [7:0] seed_load(input logic [7:0] s);
    return (s == 8'h00) ? ZERO_SEED_SUB : s;
  endfunction

endpackage

// File: rtl/sc_lfsr8.sv
// One 8-bit Fibonacci LFSR with seed reload and zero-seed substitution.
// Latency: loaded value visible after the loading edge; each enabled edge steps once.
// Backpressure: none; holds state while enable is low.
module sc_lfsr8
  import sc_rng_pkg::*;
#(
  parameter logic [7:0] TAPS = TAPS_A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       restart,
  input  logic [7:0] seed,
  output logic [7:0] out
);

  // Reload has priority over stepping; the state can never reach zero
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      out <= seed_load(seed);
    end else if (enable) begin
      out <= lfsr_next(out, TAPS);
    end
  end

endmodule

// File: rtl/sc_rng_bank.sv
// Two uncorrelated LFSR streams plus a free-running mux select counter.
// Latency: all outputs registered; reload visible after edge N, first step after edge N+1.
// Backpressure: none; enable=0 holds every state. Optional macro: SC_RNG_PERIOD_LAST_EN adds 'last'.
module sc_rng_bank
  import sc_rng_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 restart,
  input  logic [WIDTH-1:0]     seed_a,
  input  logic [WIDTH-1:0]     seed_b,
  output logic [WIDTH-1:0]     rng_a,
  output logic [WIDTH-1:0]     rng_b,
  output logic [SEL_WIDTH-1:0] sel
`ifdef SC_RNG_PERIOD_LAST_EN
  ,
  output logic                 last
`endif
);

  if (WIDTH != SC_RNG_WIDTH) begin : g_bad_width
    $error("sc_rng_bank: WIDTH must be 8");
  end
  if (SEL_WIDTH < 1 || SEL_WIDTH > 8) begin : g_bad_sel_width
    $error("sc_rng_bank: SEL_WIDTH must be in 1..8");
  end

  // Data-side stream
  sc_lfsr8 #(.TAPS(TAPS_A)) u_lfsr_a (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .restart (restart),
    .seed    (seed_a),
    .out     (rng_a)
  );

  // Weight-side stream, different polynomial so the two are uncorrelated
  sc_lfsr8 #(.TAPS(TAPS_B)) u_lfsr_b (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .restart (restart),
    .seed    (seed_b),
    .out     (rng_b)
  );

  // Select counter: cleared on reload, wraps silently modulo 2^SEL_WIDTH
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      sel <= '0;
    end else if (enable) begin
      sel <= sel + 1'b1;
    end
  end

`ifdef SC_RNG_PERIOD_LAST_EN
  logic [7:0] step_cnt;

  // Count steps modulo 255 and flag the step that brings LFSR A back to its seed
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      step_cnt <= '0;
      last     <= 1'b0;
    end else if (enable) begin
      if (step_cnt == PERIOD_LAST) begin
        step_cnt <= '0;
        last     <= 1'b1;
      end else begin
        step_cnt <= step_cnt + 8'd1;
        last     <= 1'b0;
      end
    end else begin
      last <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sc_rng_bank.sv
// Randomized self-checking bench for sc_rng_bank against an orbit-table model.
// Latency: checks every output #1 after each rising edge.
// Backpressure: n/a.
module tb_sc_rng_bank;

  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          restart = 1'b0;
  logic [7:0]    seed_a = 8'h00;
  logic [7:0]    seed_b = 8'h00;
  logic [7:0]    rng_a;
  logic [7:0]    rng_b;
  logic [SW-1:0] sel;
`ifdef SC_RNG_PERIOD_LAST_EN
  logic          last;
`endif

  sc_rng_bank #(.WIDTH(8), .SEL_WIDTH(SW)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .restart (restart),
    .seed_a  (seed_a),
    .seed_b  (seed_b),
    .rng_a   (rng_a),
    .rng_b   (rng_b),
    .sel     (sel)
`ifdef SC_RNG_PERIOD_LAST_EN
    ,
    .last    (last)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each stream is a walk around its 255-entry orbit. The state is
  // the orbit position of the loaded seed plus the number of steps since load.
  logic [7:0] orbit_a [255];
  logic [7:0] orbit_b [255];
  int         pos_a   [256];
  int         pos_b   [256];
  logic [7:0] ld_a, ld_b;
  int         steps;
  logic       exp_last;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] load(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  function automatic logic [7:0] exp_a();
    return orbit_a[(pos_a[ld_a] + steps) % 255];
  endfunction

  function automatic logic [7:0] exp_b();
    return orbit_b[(pos_b[ld_b] + steps) % 255];
  endfunction

  // Apply one cycle of controls, advance the model at the edge, then check
  task automatic cyc(input logic r, input logic rs, input logic en);
    rst = r; restart = rs; enable = en;
    @(posedge clk);
    exp_last = 1'b0;
    if (r || rs) begin
      ld_a  = load(seed_a);
      ld_b  = load(seed_b);
      steps = 0;
    end else if (en) begin
      exp_last = ((steps % 255) == 254);
      steps++;
    end
    #1;
    chk("rng_a", rng_a, exp_a());
    chk("rng_b", rng_b, exp_b());
    chk("sel", sel, steps % (1 << SW));
`ifdef SC_RNG_PERIOD_LAST_EN
    chk("last", last, exp_last);
`endif
  endtask

  initial begin
    logic [7:0] v;
    int ret_a, ret_b, cnt_a, cnt_b;
    bit seen_a [256];
    bit seen_b [256];
    int last_hits;

    // Build both orbits from the feedback rules, starting at state 1
    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      orbit_a[i] = v; pos_a[v] = i;
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    end
    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      orbit_b[i] = v; pos_b[v] = i;
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[2]};
    end
    ld_a = 8'h01; ld_b = 8'h01; steps = 0;

    // Reset with known seeds, then two enabled steps
    seed_a = 8'hF3; seed_b = 8'h31;
    cyc(1, 0, 0);
    chk("reset_a", rng_a, 8'hF3);
    chk("reset_b", rng_b, 8'h31);
    chk("reset_sel", sel, 0);
    cyc(0, 0, 1);
    chk("step1_a", rng_a, 8'hE7);
    chk("step1_b", rng_b, 8'h62);
    chk("step1_sel", sel, 1);
    cyc(0, 0, 1);
    chk("step2_a", rng_a, 8'hCE);
    chk("step2_b", rng_b, 8'hC5);
    chk("step2_sel", sel, 2);

    // Zero seeds are substituted and the state never reaches zero
    seed_a = 8'h00; seed_b = 8'h00;
    cyc(1, 0, 1);
    chk("zero_a", rng_a, 8'h01);
    chk("zero_b", rng_b, 8'h01);
    cyc(0, 0, 1);
    chk("zero_step_a", rng_a, 8'h02);
    chk("zero_step_b", rng_b, 8'h02);
    for (int i = 0; i < 300; i++) begin
      cyc(0, 0, 1);
      chk("nonzero_a", rng_a != 8'h00, 1);
      chk("nonzero_b", rng_b != 8'h00, 1);
    end

    // Full period from F3 / 31; also watches the period flag
    seed_a = 8'hF3; seed_b = 8'h31;
    cyc(1, 0, 0);
    ret_a = 0; ret_b = 0; last_hits = 0;
    for (int i = 0; i < 256; i++) begin seen_a[i] = 0; seen_b[i] = 0; end
    for (int i = 1; i <= 510; i++) begin
      seed_a = 8'($urandom); seed_b = 8'($urandom);  // must be ignored
      cyc(0, 0, 1);
      if (i <= 255) begin
        if (rng_a == 8'hF3 && ret_a == 0) ret_a = i;
        if (rng_b == 8'h31 && ret_b == 0) ret_b = i;
        seen_a[rng_a] = 1; seen_b[rng_b] = 1;
      end
    end
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 256; i++) begin
      cnt_a += int'(seen_a[i]); cnt_b += int'(seen_b[i]);
    end
    chk("period_a", ret_a, 255);
    chk("period_b", ret_b, 255);
    chk("distinct_a", cnt_a, 255);
    chk("distinct_b", cnt_b, 255);

    // Hold for 5 cycles, then restart together with enable
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    seed_a = 8'h5A; seed_b = 8'hA5;
    cyc(0, 1, 1);
    chk("restart_a", rng_a, 8'h5A);
    chk("restart_b", rng_b, 8'hA5);
    chk("restart_sel", sel, 0);

    // Select wrap and reset mid-sequence
    cyc(1, 0, 0);
    chk("wrap0", sel, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 1);
      chk("wrap_seq", sel, i % 4);
    end
    cyc(1, 0, 1);
    chk("wrap_rst", sel, 0);

    // Random controls and seeds
    for (int i = 0; i < 3000; i++) begin
      seed_a = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      seed_b = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      cyc(($urandom_range(63) == 0), ($urandom_range(31) == 0), ($urandom_range(3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_rng_bank.md
Name: sc_rng_bank

Overview:
- Noise and select source for the stochastic-computing datapath.
- Contains two independent 8-bit maximal-length LFSRs with different polynomials. These provide uncorrelated random numbers to the data-side and weight-side SNG comparators.
- Contains a free-running select counter that drives the scaled-adder mux select of the dot-product unit.
- All outputs are registered and share one enable/restart control.

Parameters:
- WIDTH, 8: LFSR width. Only 8 is supported; an elaboration check fails on any other value.
- SEL_WIDTH, 2: select counter width, equal to clog2(DIMENSION). Legal range 1..8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  advance LFSRs and counter this cycle
- restart  in  1  synchronous reload of seeds and clear of counter
- seed_a  in  WIDTH  seed for LFSR A (data-side stream)
- seed_b  in  WIDTH  seed for LFSR B (weight-side stream)
- rng_a  out  WIDTH  LFSR A state
- rng_b  out  WIDTH  LFSR B state
- sel  out  SEL_WIDTH  select counter value

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst is synchronous, active-high, and has the highest priority.
  - On reset: rng_a <= load(seed_a), rng_b <= load(seed_b), sel <= 0.
- Seed loading:
  - load(s) = s when s != 0; load(s) = 8'h01 when s == 0. This prevents the all-zero lock-up state.
- Control priority per cycle (highest first):
  1. rst
  2. restart: same reload as reset, independent of enable
  3. enable=1: step both LFSRs and the counter
  4. otherwise: hold all state
- LFSR step (Fibonacci, shift left):
  - next = {q[6:0], fb}.
  - LFSR A: polynomial x^8+x^6+x^5+x^4+1, fb = q[7]^q[5]^q[4]^q[3].
  - LFSR B: polynomial x^8+x^6+x^5+x^3+1, fb = q[7]^q[5]^q[4]^q[2].
  - Both have period 255 over the nonzero states; the state never becomes 0.
- Outputs:
  - rng_a and rng_b are the state registers directly; there is no combinational path from the inputs.
  - Latency: a value loaded on edge N is visible after edge N; the first stepped value is visible after edge N+1 with enable=1.
- Select counter:
  - sel increments by 1 modulo 2^SEL_WIDTH on each enabled cycle.
  - It wraps from all-ones to 0 with no flag.
- Seed changes: seed_a and seed_b are sampled only on reset or restart. Changes at other times have no effect.
- restart asserted together with enable: the reload wins; no step occurs that cycle.

Optional Feature:
- Macro: SC_RNG_PERIOD_LAST_EN.
- With the macro defined:
  - An extra output last (1 bit) and an internal 8-bit step counter are added.
  - The step counter clears on rst or restart and increments on each enabled step.
  - It wraps 254 -> 0, and on that wrap last is registered high for exactly one cycle. At that point LFSR A has returned to its loaded seed.
  - last is 0 on reset and restart.
- Without the macro: the port and the counter do not exist, and all other behaviour is identical.

Decomposition:
- Package sc_rng_pkg holds:
  - SC_RNG_WIDTH = 8
  - tap masks TAPS_A = 8'b1011_1000 and TAPS_B = 8'b1011_0100
  - ZERO_SEED_SUB = 8'h01
  - a function lfsr_next(q, taps) = {q[6:0], ^(q & taps)}
- Sub-module sc_lfsr8 is parameterised by tap mask and has ports clk, rst, enable, restart, seed, out. It is instantiated twice; the select counter and the optional period logic live in the top level.

Test Plan:
- Reset with seed_a=8'hF3, seed_b=8'h31: outputs are rng_a=F3, rng_b=31, sel=0. With enable=1, the next two edges give rng_a E7 then CE, rng_b 62 then C5, and sel 1 then 2.
- Zero seeds (seed_a=seed_b=0) with reset: rng_a=rng_b=8'h01. One enabled step gives rng_a=8'h02 and rng_b=8'h02; the state is never 0 over 300 cycles.
- Period check: enable held for 255 cycles from seed F3. rng_a returns to F3 exactly at step 255 and not earlier; the same holds for rng_b from 31. All 255 nonzero values are seen once each.
- enable=0 for 5 cycles mid-run: rng_a, rng_b and sel hold. restart=1 together with enable=1 reloads the seeds and clears sel, with no step that cycle.
- sel wrap: SEL_WIDTH=2 gives the sequence 0,1,2,3,0,1. rst asserted mid-sequence clears sel to 0 on the next edge.
- With SC_RNG_PERIOD_LAST_EN defined: last pulses high for one cycle after the 255th enabled step and again after the 510th. It stays 0 after restart until 255 further steps.
